// File: rtl/cordic_q15_to_ieee754_pkg.sv
// Shared constants and types for the Q15 to IEEE754 single-precision output stage.
package cordic_q15_to_ieee754_pkg;

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MANT_W   = 23;
    localparam int unsigned FLOAT_W  = 1 + EXP_W + MANT_W;
    localparam int unsigned Q15_W    = 16;
    localparam int unsigned Q15_FRAC = 15;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } ieee754_t;

endpackage

// File: rtl/cordic_q15_to_ieee754_norm_unit.sv
// Per-channel normaliser: captures |x|, shifts left one bit per cycle until the MSB is set,
// and assembles sign/exponent/mantissa from the shift register and shift count.
module cordic_q15_to_ieee754_norm_unit
    import cordic_q15_to_ieee754_pkg::*;
#(
    parameter int unsigned IN_W   = Q15_W,
    parameter int unsigned FRAC_W = Q15_FRAC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [IN_W-1:0]   x,
    output logic              done,
    output logic              sign,
    output logic [EXP_W-1:0]  exp,
    output logic [MANT_W-1:0] mant
);

    localparam int unsigned CNT_W   = $clog2(IN_W);
    localparam int unsigned EXP_TOP = EXP_BIAS + IN_W - 1 - FRAC_W;
    localparam int unsigned PAD_W   = MANT_W + 1 - IN_W;

    logic [IN_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             sign_q, sign_d;
    logic             zero_c;

    // Two's-complement negate of the most negative code wraps to 2^(IN_W-1), which is its magnitude.
    always_comb begin
        sr_d   = sr_q;
        n_d    = n_q;
        sign_d = sign_q;
        if (load) begin
            sign_d = x[IN_W-1];
            sr_d   = x[IN_W-1] ? IN_W'(~x + IN_W'(1)) : x;
            n_d    = '0;
        end else if (!done) begin
            sr_d = sr_q << 1;
            n_d  = n_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            n_q    <= '0;
            sign_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            n_q    <= n_d;
            sign_q <= sign_d;
        end
    end

    assign zero_c = (sr_q == '0);
    assign done   = sr_q[IN_W-1] | zero_c;
    assign sign   = sign_q & ~zero_c;
    assign exp    = zero_c ? '0 : EXP_W'(EXP_TOP - 32'(n_q));
    assign mant   = zero_c ? '0 : (MANT_W'(sr_q[IN_W-2:0]) << PAD_W);

endmodule

// File: rtl/cordic_q15_to_ieee754.sv
// CORDIC output stage: converts a signed Q15 sin/cos pair into two exact IEEE754 singles
// using two parallel iterative normalisers; data-dependent latency of 1..IN_W cycles.
module cordic_q15_to_ieee754
    import cordic_q15_to_ieee754_pkg::*;
#(
    parameter int unsigned IN_W   = Q15_W,
    parameter int unsigned FRAC_W = Q15_FRAC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic [IN_W-1:0]    sin_q15,
    input  logic [IN_W-1:0]    cos_q15,
    output logic               ready,
    output logic [FLOAT_W-1:0] sin_ieee754,
    output logic [FLOAT_W-1:0] cos_ieee754,
    output logic               valid
);

    state_e   state_q, state_d;
    logic     load_c, finish_c;
    logic     sin_done, cos_done;
    ieee754_t sin_f_c, cos_f_c;

    logic               ready_q, valid_q;
    logic [FLOAT_W-1:0] sin_q, cos_q;

    cordic_q15_to_ieee754_norm_unit #(.IN_W(IN_W), .FRAC_W(FRAC_W)) u_sin (
        .clk  (clk),
        .rst  (rst),
        .load (load_c),
        .x    (sin_q15),
        .done (sin_done),
        .sign (sin_f_c.sign),
        .exp  (sin_f_c.exp),
        .mant (sin_f_c.mant)
    );

    cordic_q15_to_ieee754_norm_unit #(.IN_W(IN_W), .FRAC_W(FRAC_W)) u_cos (
        .clk  (clk),
        .rst  (rst),
        .load (load_c),
        .x    (cos_q15),
        .done (cos_done),
        .sign (cos_f_c.sign),
        .exp  (cos_f_c.exp),
        .mant (cos_f_c.mant)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (valid_in)             state_d = ST_BUSY;
            ST_BUSY: if (sin_done && cos_done) state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load_c   = 1'b0;
        finish_c = 1'b0;
        unique case (state_q)
            ST_IDLE: load_c   = valid_in;
            ST_BUSY: finish_c = sin_done & cos_done;
            default: ;
        endcase
    end

    // Results hold between conversions; ready rises in the same cycle as the valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            sin_q   <= '0;
            cos_q   <= '0;
        end else begin
            ready_q <= (state_d == ST_IDLE);
            valid_q <= finish_c;
            if (finish_c) begin
                sin_q <= sin_f_c;
                cos_q <= cos_f_c;
            end
        end
    end

    assign ready       = ready_q;
    assign valid       = valid_q;
    assign sin_ieee754 = sin_q;
    assign cos_ieee754 = cos_q;

endmodule

// File: tb/tb_cordic_q15_to_ieee754.sv
// Directed bench for cordic_q15_to_ieee754: scoreboard of expected floats and latencies.
module tb_cordic_q15_to_ieee754;

    typedef struct {
        logic [31:0] s;
        logic [31:0] c;
        int          cap;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [15:0] sin_q15;
    logic [15:0] cos_q15;
    logic        ready;
    logic [31:0] sin_ieee754;
    logic [31:0] cos_ieee754;
    logic        valid;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   pulses = 0;
    int   exp_pulses = 0;

    cordic_q15_to_ieee754 dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .sin_q15     (sin_q15),
        .cos_q15     (cos_q15),
        .ready       (ready),
        .sin_ieee754 (sin_ieee754),
        .cos_ieee754 (cos_ieee754),
        .valid       (valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference conversion through double-precision real arithmetic.
    function automatic logic [31:0] to_single(input logic [15:0] q);
        real         r;
        logic [63:0] d;
        int          e;
        if (q == 16'h0000) return 32'h0;
        r = $itor($signed(q)) / 32768.0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic int lz(input logic [15:0] q);
        logic [15:0] m;
        int          n;
        m = q[15] ? 16'(-q) : q;
        n = 0;
        if (m == 16'h0000) return 0;
        while (!m[15]) begin
            m = m << 1;
            n++;
        end
        return n;
    endfunction

    // Called at a falling edge; capture happens at the following rising edge.
    task automatic send(input logic [15:0] s, input logic [15:0] c,
                        input logic [31:0] es, input logic [31:0] ec, input int lat);
        check("ready_at_valid_in", 32'(ready), 32'd1);
        sin_q15  = s;
        cos_q15  = c;
        valid_in = 1'b1;
        sb.push_back('{s: es, c: ec, cap: cyc + 1, lat: lat});
        exp_pulses++;
        @(negedge clk);
        valid_in = 1'b0;
        check("ready_low_busy", 32'(ready), 32'd0);
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        repeat (40) begin
            if (!seen) begin
                @(negedge clk);
                seen = (valid === 1'b1);
            end
        end
        check("valid_seen", 32'(seen), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && valid === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sin_float", sin_ieee754, e.s);
                check("cos_float", cos_ieee754, e.c);
                check("latency", 32'(cyc - e.cap), 32'(e.lat));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        sin_q15  = '0;
        cos_q15  = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_sin", sin_ieee754, 32'h0);
        check("rst_cos", cos_ieee754, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 1: half and near-one
        send(16'h4000, 16'h7FFF, 32'h3F000000, 32'h3F7FFE00, 2);
        wait_valid();
        @(negedge clk);
        check("valid_one_cycle_1", 32'(valid), 32'd0);

        // 2: minus one and zero, minimum latency
        send(16'h8000, 16'h0000, 32'hBF800000, 32'h00000000, 1);
        wait_valid();
        @(negedge clk);
        check("valid_one_cycle_2", 32'(valid), 32'd0);

        // 3: smallest magnitudes, worst-case latency
        send(16'h0001, 16'hFFFF, 32'h38000000, 32'hB8000000, 16);
        wait_valid();
        @(negedge clk);

        // 4: second valid_in while busy is dropped
        send(16'hC000, 16'h5A82, 32'hBF000000, 32'h3F350400, 2);
        sin_q15  = 16'h1234;
        cos_q15  = 16'h0001;
        valid_in = 1'b1;
        check("ready_low_drop", 32'(ready), 32'd0);
        @(negedge clk);
        valid_in = 1'b0;
        wait_valid();
        repeat (20) @(negedge clk);
        check("hold_sin", sin_ieee754, 32'hBF000000);
        check("hold_cos", cos_ieee754, 32'h3F350400);

        // 5: reset aborts an in-flight conversion
        send(16'h0001, 16'h0000, 32'h38000000, 32'h00000000, 16);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        exp_pulses--;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_sin", sin_ieee754, 32'h0);
        check("abort_cos", cos_ieee754, 32'h0);
        repeat (20) @(negedge clk);
        send(16'h0001, 16'h8000, 32'h38000000, 32'hBF800000, 16);
        wait_valid();
        @(negedge clk);

        // 6: sweep of rounded Q15 sin/cos, issued back-to-back as each result returns
        for (int deg = 0; deg < 360; deg++) begin
            real         r;
            logic [15:0] s;
            logic [15:0] c;
            int          ls;
            int          lc;
            r  = $itor(deg) * 3.14159265358979 / 180.0;
            s  = 16'(int'(32767.0 * $sin(r)));
            c  = 16'(int'(32767.0 * $cos(r)));
            ls = lz(s);
            lc = lz(c);
            send(s, c, to_single(s), to_single(c), 1 + ((ls > lc) ? ls : lc));
            wait_valid();
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("pulse_count", 32'(pulses), 32'(exp_pulses));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
